// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared types and constants for the UART command sequencer.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    EXEC,
    RESP
  } state_t;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_OK   = 8'h4B;

  // True for the two opcodes that start a command.
  function automatic logic is_opcode(input logic [7:0] b);
    return (b == OP_WRITE) || (b == OP_READ);
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_timeout.sv
// Inter-byte timeout: a down-counter reloaded by 'clear'; 'expired' flags
// the cycle in which TIMEOUT_CYC-1 idle cycles have elapsed since the last clear.
module uart_cmd_timeout #(
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count;

  // Reload on clear, otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= LOAD;
    end else if (clear) begin
      count <= LOAD;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = !clear && (count == '0);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command sequencer: parses 'W'/'R' byte commands into single-word
// SDRAM requests and returns the response bytes over the UART transmitter.
// Optional inter-byte timeout is enabled with the UART_CMD_TIMEOUT_EN macro.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int ADDR_W      = 24,
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy,
  output logic              err
);

  state_t      state;
  state_t      state_next;
  logic [1:0]  cnt;
  logic [1:0]  cnt_next;
  logic [23:0] addr_q;
  logic [15:0] rdata_q;
  logic        err_next;
  logic        latch_op;
  logic        shift_addr;
  logic        shift_data;
  logic        capture;
  logic        tx_fire;
  logic [7:0]  tx_byte;
  logic [1:0]  last_idx;
  logic        expired;

`ifdef UART_CMD_TIMEOUT_EN
  logic timeout_clear;

  assign timeout_clear = rx_valid || !((state == ADDR) || (state == DATA));

  uart_cmd_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timeout_clear),
    .expired(expired)
  );
`else
  logic timeout_unused;

  assign timeout_unused = (TIMEOUT_CYC == 0);
  assign expired        = 1'b0;
`endif

  assign mem_req  = (state == EXEC);
  assign busy     = (state != IDLE);
  assign mem_addr = addr_q[ADDR_W-1:0];
  assign last_idx = mem_we ? 2'd0 : 2'd1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, byte counter and datapath strobes.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    err_next   = 1'b0;
    latch_op   = 1'b0;
    shift_addr = 1'b0;
    shift_data = 1'b0;
    capture    = 1'b0;
    tx_fire    = 1'b0;
    tx_byte    = 8'h00;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          if (is_opcode(rx_data)) begin
            latch_op   = 1'b1;
            state_next = ADDR;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      ADDR: begin
        if (rx_valid) begin
          shift_addr = 1'b1;
          if (cnt == 2'd2) begin
            state_next = mem_we ? DATA : EXEC;
          end else begin
            cnt_next = cnt + 2'd1;
          end
        end else if (expired) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end
      end
      DATA: begin
        if (rx_valid) begin
          shift_data = 1'b1;
          if (cnt == 2'd1) begin
            state_next = EXEC;
          end else begin
            cnt_next = cnt + 2'd1;
          end
        end else if (expired) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end
      end
      EXEC: begin
        err_next = rx_valid;
        if (mem_ack) begin
          capture    = 1'b1;
          state_next = RESP;
          if (!tx_busy) begin
            tx_fire = 1'b1;
            tx_byte = mem_we ? RSP_OK : mem_rdata[15:8];
          end
        end
      end
      RESP: begin
        err_next = rx_valid;
        if (tx_start) begin
          if (cnt == last_idx) begin
            state_next = IDLE;
          end else begin
            cnt_next = cnt + 2'd1;
          end
        end else if (!tx_busy) begin
          tx_fire = 1'b1;
          if (mem_we) begin
            tx_byte = RSP_OK;
          end else if (cnt == 2'd0) begin
            tx_byte = rdata_q[15:8];
          end else begin
            tx_byte = rdata_q[7:0];
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (state_next != state) begin
      cnt_next = 2'd0;
    end
  end

  // Command registers, captured read data and registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 2'd0;
      mem_we    <= 1'b0;
      addr_q    <= 24'h0;
      mem_wdata <= 16'h0;
      rdata_q   <= 16'h0;
      tx_data   <= 8'h00;
      tx_start  <= 1'b0;
      err       <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      tx_start <= tx_fire;
      err      <= err_next;
      if (latch_op) begin
        mem_we <= (rx_data == OP_WRITE);
      end
      if (shift_addr) begin
        addr_q <= {addr_q[15:0], rx_data};
      end
      if (shift_data) begin
        mem_wdata <= {mem_wdata[7:0], rx_data};
      end
      if (capture) begin
        rdata_q <= mem_rdata;
      end
      if (tx_fire) begin
        tx_data <= tx_byte;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: stimulus pushes expected memory
// requests and response bytes; a negedge monitor pops and compares them.
module tb_uart_cmd_ctrl;

  typedef struct packed {
    logic        we;
    logic [23:0] addr;
    logic [15:0] wdata;
  } req_t;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        mem_req;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        busy;
  logic        err;

  req_t        exp_req_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [15:0] rdata_q[$];

  int n_checks;
  int n_errors;
  int err_seen;
  int exp_err;
  int cyc;
  int ack_cyc;
  logic ack_busy;
  logic first_pending;
  logic prev_req;
  logic prev_start;
  logic prev_err;

  uart_cmd_ctrl #(
    .ADDR_W     (24),
    .TIMEOUT_CYC(100)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic sendWrite(input logic [23:0] a, input logic [15:0] d);
    exp_req_q.push_back('{we: 1'b1, addr: a, wdata: d});
    exp_tx_q.push_back(8'h4B);
    applyStimulus(8'h57);
    applyStimulus(a[23:16]);
    applyStimulus(a[15:8]);
    applyStimulus(a[7:0]);
    applyStimulus(d[15:8]);
    applyStimulus(d[7:0]);
  endtask

  task automatic sendRead(input logic [23:0] a, input logic [15:0] rd,
                          input logic [7:0] hi, input logic [7:0] lo);
    exp_req_q.push_back('{we: 1'b0, addr: a, wdata: 16'h0});
    rdata_q.push_back(rd);
    exp_tx_q.push_back(hi);
    exp_tx_q.push_back(lo);
    applyStimulus(8'h52);
    applyStimulus(a[23:16]);
    applyStimulus(a[15:8]);
    applyStimulus(a[7:0]);
  endtask

  task automatic waitIdle(input string name, input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && exp_tx_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput(name, {31'h0, done}, 32'h1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_mem_req"},   {31'h0, mem_req},   32'h0);
    checkOutput({tag, "_mem_we"},    {31'h0, mem_we},    32'h0);
    checkOutput({tag, "_tx_start"},  {31'h0, tx_start},  32'h0);
    checkOutput({tag, "_busy"},      {31'h0, busy},      32'h0);
    checkOutput({tag, "_err"},       {31'h0, err},       32'h0);
    checkOutput({tag, "_mem_addr"},  {8'h0, mem_addr},   32'h0);
    checkOutput({tag, "_mem_wdata"}, {16'h0, mem_wdata}, 32'h0);
    checkOutput({tag, "_tx_data"},   {24'h0, tx_data},   32'h0);
  endtask

  // Memory model: acknowledge each request three cycles after it appears.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      if (mem_req && rst_n) begin
        repeat (3) @(posedge clk);
        #1;
        mem_ack   = 1'b1;
        mem_rdata = (!mem_we && rdata_q.size() > 0) ? rdata_q.pop_front() : 16'hDEAD;
        @(posedge clk);
        #1;
        mem_ack   = 1'b0;
        mem_rdata = 16'h0;
        @(negedge clk);
        checkOutput("req_drop_after_ack", {31'h0, mem_req}, 32'h0);
      end
    end
  end

  // Transmitter model: busy from the cycle after tx_start for 8 cycles.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        @(posedge clk);
        #1;
        tx_busy = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        tx_busy = 1'b0;
      end
    end
  end

  // Monitor: compare requests, transmitted bytes and error pulses.
  initial begin
    req_t exp;
    cyc           = 0;
    ack_cyc       = 0;
    ack_busy      = 1'b0;
    first_pending = 1'b0;
    prev_req      = 1'b0;
    prev_start    = 1'b0;
    prev_err      = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (mem_req && !prev_req) begin
          if (exp_req_q.size() == 0) begin
            checkOutput("unexpected_req", 32'h1, 32'h0);
          end else begin
            exp = exp_req_q.pop_front();
            checkOutput("req_we", {31'h0, mem_we}, {31'h0, exp.we});
            checkOutput("req_addr", {8'h0, mem_addr}, {8'h0, exp.addr});
            if (exp.we) begin
              checkOutput("req_wdata", {16'h0, mem_wdata}, {16'h0, exp.wdata});
            end
          end
        end
        if (mem_ack && mem_req) begin
          ack_cyc       = cyc;
          ack_busy      = tx_busy;
          first_pending = 1'b1;
        end
        if (tx_start) begin
          checkOutput("tx_start_gap", {31'h0, prev_start}, 32'h0);
          if (exp_tx_q.size() == 0) begin
            checkOutput("unexpected_tx", {24'h0, tx_data}, 32'hFFFF);
          end else begin
            checkOutput("tx_byte", {24'h0, tx_data}, {24'h0, exp_tx_q.pop_front()});
          end
          if (first_pending) begin
            first_pending = 1'b0;
            if (!ack_busy) begin
              checkOutput("tx_first_latency", cyc - ack_cyc, 32'h1);
            end
          end
        end
        if (err) begin
          err_seen++;
          if (prev_err) begin
            checkOutput("err_width", 32'h2, 32'h1);
          end
        end
      end
      prev_req   = mem_req;
      prev_start = tx_start;
      prev_err   = err;
    end
  end

  // Directed test sequence.
  initial begin
    logic seen;
    n_checks = 0;
    n_errors = 0;
    err_seen = 0;
    exp_err  = 0;
    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst_n = 1'b1;

    $display("[TB] write command");
    sendWrite(24'h000123, 16'hBEEF);
    waitIdle("write_idle", 200);
    checkOutput("write_err_count", err_seen, exp_err);

    $display("[TB] read command");
    sendRead(24'h000010, 16'hA55A, 8'hA5, 8'h5A);
    waitIdle("read_idle", 200);
    checkOutput("read_err_count", err_seen, exp_err);

    $display("[TB] bad opcode");
    exp_err++;
    applyStimulus(8'h41);
    repeat (3) @(negedge clk);
    checkOutput("bad_op_err_count", err_seen, exp_err);
    checkOutput("bad_op_busy", {31'h0, busy}, 32'h0);
    sendRead(24'h123456, 16'h0102, 8'h01, 8'h02);
    waitIdle("bad_op_read_idle", 200);

    $display("[TB] overrun in EXEC");
    sendRead(24'h000020, 16'h7E81, 8'h7E, 8'h81);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("overrun_req_seen", {31'h0, seen}, 32'h1);
    exp_err++;
    applyStimulus(8'h00);
    waitIdle("overrun_idle", 200);
    repeat (4) @(negedge clk);
    checkOutput("overrun_err_count", err_seen, exp_err);
    checkOutput("overrun_busy", {31'h0, busy}, 32'h0);

    $display("[TB] reset mid-command");
    applyStimulus(8'h57);
    applyStimulus(8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sendWrite(24'h000042, 16'h1234);
    waitIdle("midreset_write_idle", 200);
    checkOutput("midreset_err_count", err_seen, exp_err);

    $display("[TB] inter-byte timeout");
    applyStimulus(8'h52);
    applyStimulus(8'h00);
    repeat (120) @(negedge clk);
`ifdef UART_CMD_TIMEOUT_EN
    exp_err++;
    checkOutput("timeout_busy", {31'h0, busy}, 32'h0);
`else
    checkOutput("no_timeout_busy", {31'h0, busy}, 32'h1);
`endif
    checkOutput("timeout_err_count", err_seen, exp_err);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    checkOutput("req_queue_empty", exp_req_q.size(), 32'h0);
    checkOutput("tx_queue_empty", exp_tx_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
